// File: rtl/fd_pixel_fetch.sv
// fd_pixel_fetch: fetches a centre pixel and its 16 radius-3 circle neighbours, one RAM read per cycle
module fd_pixel_fetch #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         req,
  input  logic [14:0]  refAddr,
  input  logic [7:0]   refX,
  input  logic [6:0]   refY,
  output logic         busy,
  output logic         valid,
  output logic [7:0]   refPixel,
  output logic [127:0] adjPixel,
  output logic [14:0]  memAddr,
  input  logic [7:0]   memData
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  // fetch index k = 16..0, two's complement nibbles; k=0 is the centre
  localparam logic [16:0][3:0] DX = 68'hFEDDDEF0123332100;
  localparam logic [16:0][3:0] DY = 68'hDEF012333210FEDD0;
  state_t state, state_nx;
  logic [4:0] k;
  logic [14:0] ref_addr;
  logic [7:0] ref_x;
  logic [6:0] ref_y;
  logic signed [3:0] dx, dy;
  logic signed [9:0] xs;
  logic signed [8:0] ys;
  logic signed [14:0] off;
  logic oob, cap_oob, cap_ref, cap_adj;
  logic [3:0] slot;
  logic [7:0] ref_sh, cap;
  logic [127:0] adj_sh;
  always_comb begin
    dx = $signed(DX[k]);
    dy = $signed(DY[k]);
    off = 15'(dy) * 15'(IMG_W) + 15'(dx);
    xs = $signed({2'b0, ref_x}) + 10'(dx);
    ys = $signed({2'b0, ref_y}) + 9'(dy);
    oob = xs[9] | (xs >= 10'(IMG_W)) | ys[8] | (ys >= 9'(IMG_H));
    // data of index k-1 arrives while index k is issued; index 16 arrives in DRAIN
    cap_ref = state == ISSUE && k == 5'd1;
    cap_adj = (state == ISSUE && k >= 5'd2) || state == DRAIN;
    slot = state == DRAIN ? 4'd15 : 4'(k - 5'd2);
    cap = cap_oob ? ref_sh : memData;
    busy = state != IDLE;
    valid = state == DONE;
    state_nx = state;
    case (state)
      IDLE:  state_nx = req ? ISSUE : IDLE;
      ISSUE: state_nx = k == 5'd16 ? DRAIN : ISSUE;
      DRAIN: state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      k <= '0;
      ref_addr <= '0;
      ref_x <= '0;
      ref_y <= '0;
      memAddr <= '0;
      cap_oob <= 1'b0;
      ref_sh <= '0;
      adj_sh <= '0;
      refPixel <= '0;
      adjPixel <= '0;
    end else begin
      state <= state_nx;
      k <= state == ISSUE ? k + 5'd1 : 5'd0;
      if (state == IDLE && req) begin
        ref_addr <= refAddr;
        ref_x <= refX;
        ref_y <= refY;
      end
      if (state == ISSUE) begin
        memAddr <= oob ? ref_addr : ref_addr + off;
        cap_oob <= oob;
      end
      if (cap_ref) ref_sh <= memData;
      if (cap_adj) adj_sh[{slot, 3'b000} +: 8] <= cap;
      if (state == DRAIN) begin
        refPixel <= ref_sh;
        adjPixel <= {cap, adj_sh[119:0]};
      end
    end
  end
endmodule

// File: tb/tb_fd_pixel_fetch.sv
// tb_fd_pixel_fetch: table vectors, random fetches and corner sequences against a coordinate-level model
module tb_fd_pixel_fetch;
  logic clock = 1'b0;
  logic nReset, req, ovr;
  logic [14:0] refAddr, memAddr;
  logic [7:0] refX, refPixel, memData, rnd;
  logic [6:0] refY;
  logic busy, valid;
  logic [127:0] adjPixel;
  logic [7:0] ram [32768];
  int n_chk = 0, n_fail = 0;
  localparam int DXT [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int DYT [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
  typedef struct {int x; int y; logic [7:0] ref_e; logic [7:0] p0_e;} vec_t;
  vec_t tbl [5];

  fd_pixel_fetch dut (
    .clock(clock), .nReset(nReset), .req(req), .refAddr(refAddr), .refX(refX), .refY(refY),
    .busy(busy), .valid(valid), .refPixel(refPixel), .adjPixel(adjPixel),
    .memAddr(memAddr), .memData(memData)
  );

  always #5 clock = ~clock;
  assign memData = ovr ? rnd : ram[memAddr];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_addr(input int x, input int y, input int k);
    int nx, ny;
    if (k == 0) return y * 160 + x;
    nx = x + DXT[k-1];
    ny = y + DYT[k-1];
    return (nx >= 0 && nx < 160 && ny >= 0 && ny < 120) ? ny * 160 + nx : y * 160 + x;
  endfunction

  function automatic logic [127:0] exp_adj(input int x, input int y);
    logic [127:0] a;
    for (int i = 0; i < 16; i++) a[8*i +: 8] = ram[exp_addr(x, y, i + 1)];
    return a;
  endfunction

  task automatic fetch(input int x, input int y, input bit keep);
    refX = 8'(x);
    refY = 7'(y);
    refAddr = 15'(y * 160 + x);
    req = 1'b1;
    @(posedge clock); #1;
    if (!keep) req = 1'b0;
    chk("busy_after_req", 128'(busy), 128'(1));
    for (int k = 0; k < 17; k++) begin
      @(posedge clock); #1;
      chk($sformatf("memAddr_k%0d", k), 128'(memAddr), 128'(exp_addr(x, y, k)));
      chk("valid_early", 128'(valid), 128'(0));
    end
    @(posedge clock); #1;
    chk("valid_pulse", 128'(valid), 128'(1));
    chk("busy_in_done", 128'(busy), 128'(1));
    chk($sformatf("refPixel_%0d_%0d", x, y), 128'(refPixel), 128'(ram[y * 160 + x]));
    chk($sformatf("adjPixel_%0d_%0d", x, y), adjPixel, exp_adj(x, y));
    @(posedge clock); #1;
    chk("valid_single", 128'(valid), 128'(0));
    chk("busy_cleared", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [7:0] r0;
    logic [127:0] a0;
    int vhits;
    tbl[0] = '{10, 10, 8'h4A, 8'h6A};
    tbl[1] = '{0, 0, 8'h55, 8'h55};
    tbl[2] = '{159, 60, 8'h1F, 8'h3F};
    tbl[3] = '{159, 119, 8'hFF, 8'h1F};
    tbl[4] = '{5, 119, 8'h65, 8'h85};
    for (int a = 0; a < 32768; a++) ram[a] = 8'(a);
    ram[0] = 8'h55;
    nReset = 1'b0; req = 1'b0; ovr = 1'b0; rnd = '0;
    refX = '0; refY = '0; refAddr = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(valid), 128'(0));
    chk("rst_refPixel", 128'(refPixel), 128'(0));
    chk("rst_adjPixel", adjPixel, 128'(0));
    chk("rst_memAddr", 128'(memAddr), 128'(0));
    nReset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      fetch(tbl[i].x, tbl[i].y, 1'b0);
      chk($sformatf("tbl%0d_ref", i), 128'(refPixel), 128'(tbl[i].ref_e));
      chk($sformatf("tbl%0d_p0", i), 128'(adjPixel[7:0]), 128'(tbl[i].p0_e));
    end
    chk("p4_interior", 128'(adjPixel[39:32]), 128'(8'h68));
    // abort mid-ISSUE by reset
    refX = 8'd20; refY = 7'd30; refAddr = 15'(30 * 160 + 20); req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    nReset = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(valid), 128'(0));
    chk("abort_adjPixel", adjPixel, 128'(0));
    chk("abort_refPixel", 128'(refPixel), 128'(0));
    @(posedge clock); #1;
    nReset = 1'b1;
    repeat (30) begin
      @(posedge clock); #1;
      chk("abort_no_valid", 128'(valid), 128'(0));
    end
    fetch(20, 30, 1'b0);
    for (int a = 0; a < 32768; a++) ram[a] = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      int x, y;
      x = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(157, 159)) : $urandom_range(0, 159);
      y = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? $urandom_range(0, 2) : $urandom_range(117, 119)) : $urandom_range(0, 119);
      fetch(x, y, 1'b0);
    end
    // req held high across three back-to-back fetches
    fetch(40, 50, 1'b1);
    fetch(159, 0, 1'b1);
    fetch(2, 118, 1'b0);
    r0 = refPixel;
    a0 = adjPixel;
    ovr = 1'b1;
    vhits = 0;
    repeat (50) begin
      rnd = 8'($urandom);
      @(posedge clock); #1;
      if (valid) vhits++;
    end
    ovr = 1'b0;
    chk("hold_valid_count", 128'(vhits), 128'(0));
    chk("hold_refPixel", 128'(refPixel), 128'(r0));
    chk("hold_adjPixel", adjPixel, a0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
